condlogic_it: RTL and testbench
===============================

// Module: condlogic_it
// PURPOSE
//  Generalised condition/flag unit for the multicycle ARM core. Its inputs come from the main
//  decoder FSM (state strobes) and from the ALU flags. Its outputs are the qualified
//  PCWrite/RegWrite/MemWrite signals to the datapath.
//  Adds three things: parametrised flag-write groups, explicit decode-latch and ALUWB-commit
//  strobes, and an IT-block sequencer that predicates up to IT_MAX following instructions.
// PARAMETERS
//  FLAG_GROUPS  2  independently written NZCV groups; legal 1,2,4; group width = 4/FLAG_GROUPS, MSB group = N side
//  IT_MAX       4  max instructions in one IT block; legal 1..4
// PORTS
//  clk          in   1            core clock, all state on rising edge
//  reset        in   1            asynchronous, active-low reset
//  Cond         in   4            instruction cond field
//  ALUFlags     in   4            {N,Z,C,V} from ALU
//  FlagW        in   FLAG_GROUPS  per-group flag write request from decoder
//  CondLatch    in   1            decode-state strobe: evaluate and capture condition
//  FlagCommit   in   1            ALUWB-state strobe: commit pending flag writes
//  InstrDone    in   1            instruction retire strobe (FSM returns to FETCH)
//  PCS          in   1            instruction writes PC
//  NextPC       in   1            FSM unconditional PC increment
//  RegW         in   1            unqualified register write
//  MemW         in   1            unqualified memory write
//  ITStart      in   1            current instruction is IT; load sequencer
//  ITFirstCond  in   4            IT base condition
//  ITLen        in   3            instructions covered, 1..IT_MAX
//  ITThen       in   IT_MAX       bit i: 1 = then (base cond), 0 = else (base cond, LSB inverted)
//  PCWrite      out  1            NextPC | (PCS & CondExD)
//  RegWrite     out  1            RegW & CondExD
//  MemWrite     out  1            MemW & CondExD
//  Flags        out  4            architectural NZCV
//  EffCond      out  4            condition actually evaluated (IT-substituted)
//  InIT         out  1            sequencer active
//  ITErr        out  1            one-cycle pulse on illegal IT request
// BEHAVIOUR
//  Reset: Flags=0, pending=0, CondExD=0, sequencer IDLE, idx=0, ITErr=0.
//   Hence RegWrite=MemWrite=0 and PCWrite=NextPC.
//  EffCond: Cond when IDLE. When ACTIVE: {ITFirstCond_r[3:1], ITFirstCond_r[0]^~ITThen_r[idx]}.
//  CondEx: combinational from EffCond and Flags, standard ARM table; 1110 = always.
//  1111 (NV) = always, unless the macro below is defined.
//  CondLatch edge: CondExD<=CondEx; pending<=FlagW & {FLAG_GROUPS{CondEx}}.
//  FlagCommit edge: each group g with pending[g]=1 loads ALUFlags slice; pending<=0.
//   Flags update 1 cycle after FlagCommit.
//  CondLatch and FlagCommit in the same cycle: commit uses old pending; pending reloads new.
//  Sequencer IDLE, ITStart, ITLen in 1..IT_MAX:
//   ACTIVE on next edge; capture cond/then; rem=ITLen; idx=0.
//   InstrDone in the same cycle belongs to the IT instruction and is not counted.
//  ITLen=0 or ITLen>IT_MAX: ITErr pulse; stay IDLE.
//  ITStart while ACTIVE (nested IT): ITErr pulse; state unchanged.
//  ITFirstCond=1110: ITThen forced to all-ones on capture (no AL else).
//  ACTIVE with InstrDone: idx++, rem--; rem reaching 0 -> IDLE.
//  ACTIVE and PCS&CondExD at InstrDone (taken branch): -> IDLE immediately.
//  Async reset mid-block: immediate IDLE and all state cleared.
// CONFIGURATION
//  COND_NV_UNDEF_EN defined: EffCond=1111 gives CondEx=0 and adds output Undef (1 bit).
//   Undef pulses 1 cycle after a CondLatch with EffCond=1111; RegWrite/MemWrite/PCS suppressed.
//  Not defined: 1111 = always; no Undef port.
// STRUCTURE
//  Shared package condlogic_pkg:
//   COND_EQ..COND_AL, COND_NV localparams; FLAG_N=3/Z=2/C=1/V=0 indices;
//   it_state_t {IT_IDLE, IT_ACTIVE}.
//  Sub-module cond_eval (combinational EffCond+Flags -> CondEx); one instance.
//  Flag groups built with a generate loop of flopenr.
// TESTING
//  1. Flags=0100, Cond=0000 (EQ), RegW=1, CondLatch -> RegWrite=1 next cycle.
//     Cond=0001 -> RegWrite=0.
//  2. FLAG_GROUPS=2, FlagW=10, CondLatch then FlagCommit, ALUFlags=1111 from Flags=0000
//     -> Flags=1100 one cycle after commit.
//  3. ITStart, ITFirstCond=0000, ITLen=3, ITThen=0101, Z=1; three InstrDone
//     -> EffCond 0000, 0001, 0000, CondExD 1, 0, 1; InIT falls after the third InstrDone.
//  4. ITStart with ITLen=0, and ITStart while ACTIVE -> ITErr one-cycle pulse; InIT and idx unchanged.
//  5. Taken branch on 2nd of 4 IT slots -> IDLE; reset low mid-block -> InIT=0, Flags=0 at once.
//  6. With COND_NV_UNDEF_EN, Cond=1111, MemW=1, CondLatch -> Undef=1, MemWrite=0.

Source files
------------

// File: rtl/condlogic_pkg.sv
// Shared condition codes, NZCV bit indices and IT sequencer state type
// for the condlogic_it condition/flag unit.
package condlogic_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;

endpackage

// File: rtl/condlogic_it_cond_eval.sv
// Combinational ARM condition evaluator: EffCond + NZCV -> CondEx.
// COND_NV_UNDEF_EN makes NV evaluate false instead of always.
module cond_eval
  import condlogic_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condex
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_condex = 1'b0;
    case (i_cond)
      COND_EQ: o_condex = w_z;
      COND_NE: o_condex = ~w_z;
      COND_CS: o_condex = w_c;
      COND_CC: o_condex = ~w_c;
      COND_MI: o_condex = w_n;
      COND_PL: o_condex = ~w_n;
      COND_VS: o_condex = w_v;
      COND_VC: o_condex = ~w_v;
      COND_HI: o_condex = w_c & ~w_z;
      COND_LS: o_condex = ~w_c | w_z;
      COND_GE: o_condex = (w_n == w_v);
      COND_LT: o_condex = (w_n != w_v);
      COND_GT: o_condex = ~w_z & (w_n == w_v);
      COND_LE: o_condex = w_z | (w_n != w_v);
      COND_AL: o_condex = 1'b1;
`ifdef COND_NV_UNDEF_EN
      COND_NV: o_condex = 1'b0;
`else
      COND_NV: o_condex = 1'b1;
`endif
      default: o_condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_it_flopenr.sv
// Enabled register with asynchronous active-low reset; one per flag group.
module flopenr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/condlogic_it.sv
// Condition/flag unit with grouped flag writes and IT-block sequencer.
// Optional COND_NV_UNDEF_EN: NV never executes and raises Undef.
module condlogic_it
  import condlogic_pkg::*;
#(
  parameter int unsigned FLAG_GROUPS = 2,
  parameter int unsigned IT_MAX      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             Cond,
  input  logic [3:0]             ALUFlags,
  input  logic [FLAG_GROUPS-1:0] FlagW,
  input  logic                   CondLatch,
  input  logic                   FlagCommit,
  input  logic                   InstrDone,
  input  logic                   PCS,
  input  logic                   NextPC,
  input  logic                   RegW,
  input  logic                   MemW,
  input  logic                   ITStart,
  input  logic [3:0]             ITFirstCond,
  input  logic [2:0]             ITLen,
  input  logic [IT_MAX-1:0]      ITThen,
  output logic                   PCWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic [3:0]             Flags,
  output logic [3:0]             EffCond,
  output logic                   InIT,
  output logic                   ITErr
`ifdef COND_NV_UNDEF_EN
  ,
  output logic                   Undef
`endif
);

  localparam int unsigned GW = 4 / FLAG_GROUPS;

  logic [FLAG_GROUPS-1:0] r_pending;
  logic                   r_condexd;
  logic                   w_condex;
  logic [3:0]             w_flags;
  logic [3:0]             w_effcond;
  logic                   w_len_ok;

  it_state_t  r_state, w_state_nxt;
  logic [3:0] r_it_cond, w_it_cond_nxt;
  logic [3:0] r_it_then, w_it_then_nxt;
  logic [2:0] r_rem, w_rem_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_iterr, w_iterr_nxt;

  // Group g owns bits [g*GW +: GW]; the top group holds N.
  for (genvar g = 0; g < FLAG_GROUPS; g++) begin : g_flag_grp
    flopenr #(.WIDTH(GW)) u_grp (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_en    (FlagCommit & r_pending[g]),
      .i_d     (ALUFlags[g*GW +: GW]),
      .o_q     (w_flags[g*GW +: GW])
    );
  end

  assign w_effcond = (r_state == IT_ACTIVE)
                   ? {r_it_cond[3:1], r_it_cond[0] ^ ~r_it_then[r_idx]}
                   : Cond;

  cond_eval u_cond_eval (
    .i_cond   (w_effcond),
    .i_flags  (w_flags),
    .o_condex (w_condex)
  );

  // A simultaneous CondLatch reloads pending, so the commit sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_condexd <= 1'b0;
    end else if (CondLatch) begin
      r_condexd <= w_condex;
      r_pending <= FlagW & {FLAG_GROUPS{w_condex}};
    end else if (FlagCommit) begin
      r_pending <= '0;
    end
  end

  assign w_len_ok = (ITLen != 3'd0) && (32'(ITLen) <= IT_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_it_cond_nxt = r_it_cond;
    w_it_then_nxt = r_it_then;
    w_rem_nxt     = r_rem;
    w_idx_nxt     = r_idx;
    w_iterr_nxt   = 1'b0;
    case (r_state)
      IT_IDLE: begin
        if (ITStart) begin
          if (w_len_ok) begin
            w_state_nxt   = IT_ACTIVE;
            w_it_cond_nxt = ITFirstCond;
            w_it_then_nxt = (ITFirstCond == COND_AL) ? '1 : 4'(ITThen);
            w_rem_nxt     = ITLen;
            w_idx_nxt     = '0;
          end else begin
            w_iterr_nxt = 1'b1;
          end
        end
      end
      IT_ACTIVE: begin
        if (ITStart) begin
          w_iterr_nxt = 1'b1;
        end else if (InstrDone) begin
          if ((PCS & r_condexd) || (r_rem == 3'd1)) begin
            w_state_nxt = IT_IDLE;
            w_rem_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_rem_nxt = r_rem - 3'd1;
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      default: w_state_nxt = IT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IT_IDLE;
      r_it_cond <= '0;
      r_it_then <= '0;
      r_rem     <= '0;
      r_idx     <= '0;
      r_iterr   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_it_cond <= w_it_cond_nxt;
      r_it_then <= w_it_then_nxt;
      r_rem     <= w_rem_nxt;
      r_idx     <= w_idx_nxt;
      r_iterr   <= w_iterr_nxt;
    end
  end

`ifdef COND_NV_UNDEF_EN
  logic r_undef;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_undef <= 1'b0;
    else        r_undef <= CondLatch & (w_effcond == COND_NV);
  end
  assign Undef = r_undef;
`endif

  assign PCWrite  = NextPC | (PCS & r_condexd);
  assign RegWrite = RegW & r_condexd;
  assign MemWrite = MemW & r_condexd;
  assign Flags    = w_flags;
  assign EffCond  = w_effcond;
  assign InIT     = (r_state == IT_ACTIVE);
  assign ITErr    = r_iterr;

endmodule

// File: tb/tb_condlogic_it.sv
// Randomised + directed bench for condlogic_it against a queue-based IT model.
module tb_condlogic_it;

  localparam int unsigned FG  = 2;
  localparam int unsigned ITM = 4;
  localparam int unsigned GW  = 4 / FG;
`ifdef COND_NV_UNDEF_EN
  localparam logic NV_TAKEN = 1'b0;
`else
  localparam logic NV_TAKEN = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    Cond, ALUFlags, ITFirstCond;
  logic [FG-1:0] FlagW;
  logic          CondLatch, FlagCommit, InstrDone, PCS, NextPC, RegW, MemW, ITStart;
  logic [2:0]    ITLen;
  logic [ITM-1:0] ITThen;
  logic          PCWrite, RegWrite, MemWrite, InIT, ITErr;
  logic [3:0]    Flags, EffCond;
  logic          Undef;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [3:0]    m_flags;
  logic [FG-1:0] m_pend;
  logic          m_cexd;
  logic          m_iterr;
  logic          m_undef;
  logic [3:0]    m_q[$];

  condlogic_it #(.FLAG_GROUPS(FG), .IT_MAX(ITM)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .FlagCommit(FlagCommit), .InstrDone(InstrDone),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .ITStart(ITStart),
    .ITFirstCond(ITFirstCond), .ITLen(ITLen), .ITThen(ITThen),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .EffCond(EffCond), .InIT(InIT), .ITErr(ITErr)
`ifdef COND_NV_UNDEF_EN
    , .Undef(Undef)
`endif
  );
`ifndef COND_NV_UNDEF_EN
  assign Undef = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ARM condition rules: pairs share a base test, odd code inverts it.
  function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return NV_TAKEN;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] model_eff();
    return (m_q.size() != 0) ? m_q[0] : Cond;
  endfunction

  task automatic model_reset();
    m_flags = '0; m_pend = '0; m_cexd = 1'b0; m_iterr = 1'b0; m_undef = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge();
    logic [3:0] eff;
    logic       ce, old_cexd;
    eff = model_eff();
    ce = holds(eff, m_flags);
    old_cexd = m_cexd;
    if (FlagCommit)
      for (int b = 0; b < 4; b++)
        if (m_pend[b / GW]) m_flags[b] = ALUFlags[b];
    if (CondLatch) begin
      m_pend = ce ? FlagW : '0;
      m_cexd = ce;
    end else if (FlagCommit) begin
      m_pend = '0;
    end
    m_undef = CondLatch && (eff == 4'b1111) && !NV_TAKEN;
    m_iterr = 1'b0;
    if (ITStart) begin
      if (m_q.size() != 0 || ITLen == 0 || ITLen > ITM) m_iterr = 1'b1;
      else
        for (int i = 0; i < int'(ITLen); i++)
          m_q.push_back((ITThen[i] || ITFirstCond == 4'b1110) ? ITFirstCond : (ITFirstCond ^ 4'b0001));
    end else if (InstrDone && m_q.size() != 0) begin
      if (PCS && old_cexd) m_q.delete();
      else void'(m_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    check_eq("PCWrite",  PCWrite,  NextPC | (PCS & m_cexd));
    check_eq("RegWrite", RegWrite, RegW & m_cexd);
    check_eq("MemWrite", MemWrite, MemW & m_cexd);
    check_eq("Flags",    Flags,    m_flags);
    check_eq("EffCond",  EffCond,  model_eff());
    check_eq("InIT",     InIT,     m_q.size() != 0);
    check_eq("ITErr",    ITErr,    m_iterr);
    check_eq("Undef",    Undef,    m_undef);
  endtask

  task automatic clear_inputs();
    Cond = '0; ALUFlags = '0; FlagW = '0; CondLatch = 0; FlagCommit = 0; InstrDone = 0;
    PCS = 0; NextPC = 0; RegW = 0; MemW = 0; ITStart = 0; ITFirstCond = '0; ITLen = '0; ITThen = '0;
  endtask

  // Called at a falling edge with inputs driven; returns at the next falling edge.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_flags(input logic [3:0] f);
    clear_inputs();
    Cond = 4'b1110; FlagW = '1; CondLatch = 1;
    tick();
    clear_inputs();
    FlagCommit = 1; ALUFlags = f;
    tick();
    clear_inputs();
  endtask

  task automatic randomize_inputs();
    Cond        = 4'($urandom);
    ALUFlags    = 4'($urandom);
    FlagW       = FG'($urandom);
    CondLatch   = ($urandom_range(0, 2) == 0);
    FlagCommit  = ($urandom_range(0, 2) == 0);
    InstrDone   = ($urandom_range(0, 2) == 0);
    PCS         = ($urandom_range(0, 3) == 0);
    NextPC      = 1'($urandom);
    RegW        = 1'($urandom);
    MemW        = 1'($urandom);
    ITStart     = ($urandom_range(0, 5) == 0);
    ITFirstCond = 4'($urandom);
    ITLen       = 3'($urandom);
    ITThen      = ITM'($urandom);
  endtask

  initial begin
    logic [3:0] exp_eff [3];
    logic       exp_cx  [3];
    exp_eff[0] = 4'b0000; exp_eff[1] = 4'b0001; exp_eff[2] = 4'b0000;
    exp_cx[0]  = 1'b1;    exp_cx[1]  = 1'b0;    exp_cx[2]  = 1'b1;

    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_flags", Flags, 4'b0000);
    check_eq("rst_regwrite", RegWrite, 1'b0);
    check_eq("rst_init", InIT, 1'b0);
    NextPC = 1;
    #1 check_eq("rst_pcwrite", PCWrite, 1'b1);
    NextPC = 0;
    reset = 1'b1;
    @(negedge clk);

    // 1: EQ with Z set executes, NE does not
    set_flags(4'b0100);
    Cond = 4'b0000; RegW = 1; CondLatch = 1;
    tick();
    check_eq("t1_eq_regwrite", RegWrite, 1'b1);
    Cond = 4'b0001;
    tick();
    check_eq("t1_ne_regwrite", RegWrite, 1'b0);

    // 2: only the NZ group is written
    set_flags(4'b0000);
    Cond = 4'b1110; FlagW = 2'b10; CondLatch = 1;
    tick();
    clear_inputs();
    FlagCommit = 1; ALUFlags = 4'b1111;
    tick();
    clear_inputs();
    check_eq("t2_flags", Flags, 4'b1100);

    // 3: three-slot IT block, then/else/then with Z=1
    set_flags(4'b0100);
    ITStart = 1; ITFirstCond = 4'b0000; ITLen = 3'd3; ITThen = 4'b0101;
    tick();
    clear_inputs();
    check_eq("t3_init_start", InIT, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_eq("t3_effcond", EffCond, exp_eff[k]);
      CondLatch = 1; RegW = 1; Cond = 4'b1110;
      tick();
      CondLatch = 0;
      check_eq("t3_condexd", RegWrite, exp_cx[k]);
      InstrDone = 1;
      tick();
      InstrDone = 0;
      check_eq("t3_init", InIT, k < 2);
    end
    clear_inputs();

    // 4: illegal length and nested IT
    ITStart = 1; ITLen = 3'd0;
    tick();
    clear_inputs();
    check_eq("t4_err_len0", ITErr, 1'b1);
    check_eq("t4_idle_len0", InIT, 1'b0);
    tick();
    check_eq("t4_err_clear", ITErr, 1'b0);
    ITStart = 1; ITFirstCond = 4'b1110; ITLen = 3'd4; ITThen = 4'b0000;
    tick();
    clear_inputs();
    InstrDone = 1;
    tick();
    clear_inputs();
    ITStart = 1; ITFirstCond = 4'b0000; ITLen = 3'd2; ITThen = 4'b1111;
    tick();
    clear_inputs();
    check_eq("t4_err_nested", ITErr, 1'b1);
    check_eq("t4_init_nested", InIT, 1'b1);
    check_eq("t4_eff_nested", EffCond, 4'b1110);

    // 5: taken branch in slot 2 of 4 ends the block
    PCS = 1; CondLatch = 1;
    tick();
    CondLatch = 0; InstrDone = 1;
    tick();
    clear_inputs();
    check_eq("t5_branch_idle", InIT, 1'b0);

    set_flags(4'b1010);
    ITStart = 1; ITFirstCond = 4'b0010; ITLen = 3'd4; ITThen = 4'b1111;
    tick();
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("t5_rst_init", InIT, 1'b0);
    check_eq("t5_rst_flags", Flags, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

`ifdef COND_NV_UNDEF_EN
    // 6: NV raises Undef and blocks the memory write
    Cond = 4'b1111; MemW = 1; CondLatch = 1;
    tick();
    CondLatch = 0;
    check_eq("t6_undef", Undef, 1'b1);
    check_eq("t6_memwrite", MemWrite, 1'b0);
    clear_inputs();
`endif

    for (int n = 0; n < 600; n++) begin
      randomize_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
